layer_out_packer: RTL

//  Serial-to-parallel collector: the receive end of the word-serial
//  (data, addr, en) stream that layer buffers emit toward the next layer.

---
 rtl/layer_out_packer.sv | 108 ++++++++++
 1 files changed

// File: rtl/layer_out_packer.sv
// layer_out_packer
//   Receive end of a word-serial (data, addr, en) stream. Collects N_WORDS
//   signed words into a shadow buffer. The completed frame is copied to a held
//   output vector, and a one-cycle valid strobe marks the new frame. The next
//   frame can stream into the shadow while the previous frame stays on o_dout.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_din          signed word from the upstream stream
//   i_din_en       i_din / i_din_addr valid this cycle
//   i_din_addr     word index 0..N_WORDS-1 (larger values are ignored)
//   o_dout         packed frame; word i at o_dout[i*DATA_W +: DATA_W]
//   o_dout_valid   one-cycle pulse in the cycle after the last word is accepted
//   o_seq_err      sticky ordering error flag (tied 0 unless SEQ_CHECK_EN)
//
// Build option
//   SEQ_CHECK_EN   when defined, words must arrive in order 0..N_WORDS-1.
//                  An out-of-order or out-of-range word sets o_seq_err. That
//                  word is not written, and the frame is dropped. The frame
//                  resyncs on the next address 0.
module layer_out_packer #(
  parameter int N_WORDS = 120,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 7
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_W-1:0]             i_din,
  input  logic                          i_din_en,
  input  logic [ADDR_W-1:0]             i_din_addr,
  output logic [0:N_WORDS*DATA_W-1]     o_dout,
  output logic                          o_dout_valid,
  output logic                          o_seq_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  logic [DATA_W-1:0]          r_shadow [N_WORDS];
  logic [0:N_WORDS*DATA_W-1]  r_dout;
  logic [0:N_WORDS*DATA_W-1]  w_merged;
  logic                       r_valid;
  logic                       w_in_range;
  logic                       w_accept;
  logic                       w_complete;

  assign w_in_range = (i_din_addr <= LAST_ADDR);

`ifdef SEQ_CHECK_EN
  logic [ADDR_W-1:0] r_exp;
  logic              r_seq_err;
  logic              w_err;

  // r_exp never exceeds LAST_ADDR, so a match already implies in range.
  // After an error, r_exp returns to 0. The dropped frame can then reach
  // LAST_ADDR only by restarting cleanly from address 0.
  assign w_accept = i_din_en && w_in_range && (i_din_addr == r_exp);
  assign w_err    = i_din_en && !w_accept;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exp     <= '0;
      r_seq_err <= 1'b0;
    end else if (w_err) begin
      r_exp     <= '0;
      r_seq_err <= 1'b1;
    end else if (w_accept) begin
      r_exp <= (r_exp == LAST_ADDR) ? '0 : r_exp + 1'b1;
    end
  end

  assign o_seq_err = r_seq_err;
`else
  assign w_accept  = i_din_en && w_in_range;
  assign o_seq_err = 1'b0;
`endif

  assign w_complete = w_accept && (i_din_addr == LAST_ADDR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_WORDS; i++) r_shadow[i] <= '0;
    end else if (w_accept) begin
      r_shadow[i_din_addr] <= i_din;
    end
  end

  // The last word bypasses the shadow so that o_dout updates on the same edge
  // that accepts the last word.
  always_comb begin
    for (int i = 0; i < N_WORDS; i++) w_merged[i*DATA_W +: DATA_W] = r_shadow[i];
    w_merged[(N_WORDS-1)*DATA_W +: DATA_W] = i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_complete;
      if (w_complete) r_dout <= w_merged;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_valid;

endmodule
